// File: rtl/control_bf_in_unit.sv
// Input crossbar for the 4-butterfly NTT/INTT core: delays bank selects by the bank read
// latency, routes the eight bank words to the butterfly operand slots and flags bank conflicts.
module control_bf_in_unit #(
    parameter int unsigned data_width = 256,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            sel_b_0,
    input  logic [2:0]            sel_b_1,
    input  logic [2:0]            sel_b_2,
    input  logic [2:0]            sel_b_3,
    input  logic [2:0]            sel_b_4,
    input  logic [2:0]            sel_b_5,
    input  logic [2:0]            sel_b_6,
    input  logic [2:0]            sel_b_7,
    input  logic [data_width-1:0] q0,
    input  logic [data_width-1:0] q1,
    input  logic [data_width-1:0] q2,
    input  logic [data_width-1:0] q3,
    input  logic [data_width-1:0] q4,
    input  logic [data_width-1:0] q5,
    input  logic [data_width-1:0] q6,
    input  logic [data_width-1:0] q7,
    input  logic                  clr_err,
    output logic [data_width-1:0] bf_0_lower,
    output logic [data_width-1:0] bf_0_upper,
    output logic [data_width-1:0] bf_1_lower,
    output logic [data_width-1:0] bf_1_upper,
    output logic [data_width-1:0] bf_2_lower,
    output logic [data_width-1:0] bf_2_upper,
    output logic [data_width-1:0] bf_3_lower,
    output logic [data_width-1:0] bf_3_upper,
    output logic                  out_valid,
    output logic                  perm_err
);

    localparam int unsigned StageW = 25;

    // Stage layout: {valid, sel_b_7, ..., sel_b_0}
    logic [StageW-1:0]     dly_q [RD_LAT];
    logic [StageW-1:0]     dly_d [RD_LAT];
    logic [2:0]            sel_in [8];
    logic [data_width-1:0] q_arr [8];
    logic [data_width-1:0] slot_q [8];
    logic [data_width-1:0] slot_d [8];
    logic                  out_valid_q, out_valid_d;
    logic                  perm_err_q, perm_err_d;
    logic                  dup;
    logic                  vld_dly;
    logic [23:0]           sel_dly;

    assign sel_in[0] = sel_b_0;
    assign sel_in[1] = sel_b_1;
    assign sel_in[2] = sel_b_2;
    assign sel_in[3] = sel_b_3;
    assign sel_in[4] = sel_b_4;
    assign sel_in[5] = sel_b_5;
    assign sel_in[6] = sel_b_6;
    assign sel_in[7] = sel_b_7;

    assign q_arr[0] = q0;
    assign q_arr[1] = q1;
    assign q_arr[2] = q2;
    assign q_arr[3] = q3;
    assign q_arr[4] = q4;
    assign q_arr[5] = q5;
    assign q_arr[6] = q6;
    assign q_arr[7] = q7;

    assign vld_dly = dly_q[RD_LAT-1][24];
    assign sel_dly = dly_q[RD_LAT-1][23:0];

    always_comb begin
        dly_d[0] = {in_valid, sel_b_7, sel_b_6, sel_b_5, sel_b_4,
                    sel_b_3, sel_b_2, sel_b_1, sel_b_0};
        for (int i = 1; i < int'(RD_LAT); i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // A legal select set hits every bank exactly once; any repeated index is a conflict.
    always_comb begin
        dup = 1'b0;
        for (int j = 0; j < 8; j++) begin
            for (int k = j + 1; k < 8; k++) begin
                if (sel_in[j] == sel_in[k]) begin
                    dup = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = vld_dly;
        for (int k = 0; k < 8; k++) begin
            slot_d[k] = vld_dly ? q_arr[sel_dly[3*k +: 3]] : slot_q[k];
        end
        // Set has priority over clear.
        perm_err_d = (perm_err_q & ~clr_err) | (in_valid & dup);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                dly_q[i] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                slot_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            perm_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                dly_q[i] <= dly_d[i];
            end
            for (int k = 0; k < 8; k++) begin
                slot_q[k] <= slot_d[k];
            end
            out_valid_q <= out_valid_d;
            perm_err_q  <= perm_err_d;
        end
    end

    assign bf_0_lower = slot_q[0];
    assign bf_0_upper = slot_q[1];
    assign bf_1_lower = slot_q[2];
    assign bf_1_upper = slot_q[3];
    assign bf_2_lower = slot_q[4];
    assign bf_2_upper = slot_q[5];
    assign bf_3_lower = slot_q[6];
    assign bf_3_upper = slot_q[7];
    assign out_valid  = out_valid_q;
    assign perm_err   = perm_err_q;

endmodule

// File: tb/tb_control_bf_in_unit.sv
// Scoreboard bench for control_bf_in_unit: stimulus pushes expected operand beats, a negedge
// monitor pops and compares them whenever out_valid is seen.
module tb_control_bf_in_unit;

    localparam int unsigned DW     = 256;
    localparam int unsigned RD_LAT = 2;

    typedef logic [8*DW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          clr_err = 1'b0;
    logic [23:0]   sel_r = '0;
    logic          rand_mode = 1'b0;
    logic [DW-1:0] rq [8];
    logic [DW-1:0] q_arr [8];
    int unsigned   cyc = 0;

    logic [DW-1:0] bf_0_lower, bf_0_upper, bf_1_lower, bf_1_upper;
    logic [DW-1:0] bf_2_lower, bf_2_upper, bf_3_lower, bf_3_upper;
    logic          out_valid, perm_err;
    beat_t         dut_beat;

    int            n_checks = 0;
    int            n_fail = 0;
    beat_t         exp_q[$];
    beat_t         last_exp = '0;
    beat_t         mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank word presented in cycle c by bank k; cycle-tagged so latency errors show up.
    function automatic logic [DW-1:0] qv(input int unsigned c, input int unsigned k);
        return (DW'(c) << 8) | DW'(k + 1);
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            q_arr[k] = rand_mode ? rq[k] : qv(cyc, k);
        end
    end

    assign dut_beat = {bf_3_upper, bf_3_lower, bf_2_upper, bf_2_lower,
                       bf_1_upper, bf_1_lower, bf_0_upper, bf_0_lower};

    control_bf_in_unit #(
        .data_width(DW),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sel_b_0   (sel_r[2:0]),
        .sel_b_1   (sel_r[5:3]),
        .sel_b_2   (sel_r[8:6]),
        .sel_b_3   (sel_r[11:9]),
        .sel_b_4   (sel_r[14:12]),
        .sel_b_5   (sel_r[17:15]),
        .sel_b_6   (sel_r[20:18]),
        .sel_b_7   (sel_r[23:21]),
        .q0        (q_arr[0]),
        .q1        (q_arr[1]),
        .q2        (q_arr[2]),
        .q3        (q_arr[3]),
        .q4        (q_arr[4]),
        .q5        (q_arr[5]),
        .q6        (q_arr[6]),
        .q7        (q_arr[7]),
        .clr_err   (clr_err),
        .bf_0_lower(bf_0_lower),
        .bf_0_upper(bf_0_upper),
        .bf_1_lower(bf_1_lower),
        .bf_1_upper(bf_1_upper),
        .bf_2_lower(bf_2_lower),
        .bf_2_upper(bf_2_upper),
        .bf_3_lower(bf_3_lower),
        .bf_3_upper(bf_3_upper),
        .out_valid (out_valid),
        .perm_err  (perm_err)
    );

    task automatic chk_bit(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_beat(input string name, input beat_t act, input beat_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            for (int k = 0; k < 8; k++) begin
                if (act[k*DW +: DW] !== req[k*DW +: DW]) begin
                    $display("FAIL %s: slot %0d got %h expected %h (cycle %0d)", name, k,
                             act[k*DW +: DW], req[k*DW +: DW], cyc);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk_beat("routed_beat", dut_beat, mon_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one select set this cycle; slot k expects bank sel_k's word at issue + RD_LAT.
    task automatic issue(input logic [23:0] s, input logic clr, input logic expect_out);
        beat_t e;
        for (int k = 0; k < 8; k++) begin
            e[k*DW +: DW] = qv(cyc + RD_LAT, int'(s[3*k +: 3]));
        end
        if (expect_out) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        in_valid = 1'b1;
        sel_r    = s;
        clr_err  = clr;
        step();
        in_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_perm_err", perm_err, 1'b0);
        chk_beat("reset_bf_zero", dut_beat, '0);
        rst = 1'b0;
        repeat (3) step();
        chk_bit("post_reset_out_valid", out_valid, 1'b0);

        // Identity routing
        issue(24'o76543210, 1'b0, 1'b1);
        chk_bit("identity_no_err", perm_err, 1'b0);
        repeat (4) step();

        // Reverse routing, back-to-back
        for (int i = 0; i < 4; i++) begin
            issue(24'o01234567, 1'b0, 1'b1);
        end
        chk_bit("reverse_no_err", perm_err, 1'b0);
        repeat (5) step();

        // Bank conflict: slots 0 and 5 both read bank 3
        issue(24'o76340213, 1'b0, 1'b1);
        chk_bit("conflict_err_set", perm_err, 1'b1);
        repeat (4) step();
        chk_bit("conflict_err_sticky", perm_err, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk_bit("clr_err_clears", perm_err, 1'b0);

        // Illegal selects without in_valid are not checked
        sel_r = 24'o00000000;
        repeat (2) step();
        chk_bit("no_check_when_idle", perm_err, 1'b0);

        // Set wins over clear
        issue(24'o00000000, 1'b0, 1'b1);
        chk_bit("all_same_sets_err", perm_err, 1'b1);
        issue(24'o76340213, 1'b1, 1'b1);
        chk_bit("set_wins_over_clr", perm_err, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk_bit("clr_after_set_wins", perm_err, 1'b0);
        repeat (4) step();

        // Hold: outputs freeze while q toggles and no transaction is due
        issue(24'o76543210, 1'b0, 1'b1);
        repeat (2) step();
        rand_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) begin
                rq[k] = {8{$urandom}};
            end
            step();
            chk_beat("hold_bf", dut_beat, last_exp);
            chk_bit("hold_out_valid", out_valid, 1'b0);
        end
        rand_mode = 1'b0;

        // Reset with an illegal transaction in flight
        issue(24'o76340213, 1'b0, 1'b0);
        chk_bit("midflight_err_set", perm_err, 1'b1);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        chk_bit("midflight_perm_err", perm_err, 1'b0);
        chk_beat("midflight_bf_zero", dut_beat, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_bit("midflight_out_valid", out_valid, 1'b0);
        end

        // Normal operation after reset
        issue(24'o01234567, 1'b0, 1'b1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step();
        end
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
